// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, opcodes,
// datapath mux codes and mcause values.
package mc_ctrl_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] ST_MEM_RD   = 4'd3;
    localparam logic [3:0] ST_MEM_WB   = 4'd4;
    localparam logic [3:0] ST_MEM_WR   = 4'd5;
    localparam logic [3:0] ST_EXEC     = 4'd6;
    localparam logic [3:0] ST_ALU_WB   = 4'd7;
    localparam logic [3:0] ST_BR_CMP   = 4'd8;
    localparam logic [3:0] ST_BR_RES   = 4'd9;
    localparam logic [3:0] ST_JUMP     = 4'd10;
    localparam logic [3:0] ST_UPPER    = 4'd11;
    localparam logic [3:0] ST_FENCE    = 4'd12;
    localparam logic [3:0] ST_TRAP     = 4'd13;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_SEL_ALU  = 2'b00;
    localparam logic [1:0] PC_SEL_PC4  = 2'b01;
    localparam logic [1:0] PC_SEL_TRAP = 2'b10;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_PASSB = 2'b11;

    localparam logic [3:0] CAUSE_FETCH_FAULT = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT  = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;
    localparam logic [3:0] CAUSE_ECALL_M     = 4'd11;

    // States that hold a memory request open and can therefore time out.
    function automatic logic isWaitState(input logic [3:0] s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts cycles a request has been pending without ready
// and flags the cycle in which the timeout limit is hit.
module mc_wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    input  logic clear,
    output logic timeout
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] waitCnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            waitCnt <= 8'd0;
        end else if (active && !ready) begin
            waitCnt <= waitCnt + 8'd1;
        end
    end

    // A ready arriving in the limit cycle wins over the timeout.
    assign timeout = active && !ready && (waitCnt == LIMIT);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM with memory handshakes, bus timeout and traps.
// Optional performance counters are enabled by defining MC_CTRL_PERF_EN.
//   state    | meaning
//   FETCH    | imem request, latch IR on ready
//   DECODE   | dispatch on opcode
//   MEM_ADDR | effective address; MEM_RD/MEM_WB load, MEM_WR store
//   EXEC     | ALU op, ALU_WB writes back; BR_CMP/BR_RES branch
//   JUMP     | JAL/JALR link and redirect; UPPER LUI/AUIPC; FENCE no-op
//   TRAP     | redirect to trap vector, latch mcause
module mc_control_fsm #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       sys_imm0,
    input  logic       branch_taken,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       ir_write,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] branch_op,
    output logic       trap,
    output logic [3:0] trap_cause,
    output logic [3:0] state,
    output logic       instr_retired
`ifdef MC_CTRL_PERF_EN
   ,output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);
    import mc_ctrl_pkg::*;

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255 || CNT_W < 1) begin : g_bad_param
        $error("mc_control_fsm: TIMEOUT_CYC must be 2..255 and CNT_W at least 1");
    end

    logic [3:0] stateQ, stateNext;
    logic [3:0] trapCauseQ, causeNext;
    logic       waitReady, waitTimeout;

    assign waitReady = (stateQ == ST_FETCH) ? imem_ready : dmem_ready;

    mc_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .active  (isWaitState(stateQ)),
        .ready   (waitReady),
        .clear   (stateNext != stateQ),
        .timeout (waitTimeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ     <= ST_FETCH;
            trapCauseQ <= 4'd0;
        end else begin
            stateQ <= stateNext;
            if (stateNext == ST_TRAP) begin
                trapCauseQ <= causeNext;
            end
        end
    end

    assign state      = stateQ;
    assign trap_cause = rst ? 4'd0 : trapCauseQ;

    always_comb begin
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        pc_write      = 1'b0;
        pc_sel        = PC_SEL_ALU;
        reg_write     = 1'b0;
        wb_sel        = WB_SEL_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = 1'b0;
        alu_op        = ALU_OP_ADD;
        branch_op     = 3'b000;
        trap          = 1'b0;
        instr_retired = 1'b0;
        stateNext     = ST_FETCH;
        causeNext     = trapCauseQ;
        if (!rst) begin
            case (stateQ)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write  = 1'b1;
                        stateNext = ST_DECODE;
                    end else if (waitTimeout) begin
                        stateNext = ST_TRAP;
                        causeNext = CAUSE_FETCH_FAULT;
                    end else begin
                        stateNext = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    case (opcode)
                        OPC_LOAD, OPC_STORE: stateNext = ST_MEM_ADDR;
                        OPC_OP, OPC_OP_IMM:  stateNext = ST_EXEC;
                        OPC_BRANCH:          stateNext = ST_BR_CMP;
                        OPC_JAL, OPC_JALR:   stateNext = ST_JUMP;
                        OPC_LUI, OPC_AUIPC:  stateNext = ST_UPPER;
                        OPC_FENCE:           stateNext = ST_FENCE;
                        OPC_SYSTEM: begin
                            stateNext = ST_TRAP;
                            if (funct3 == 3'b000) begin
                                causeNext = sys_imm0 ? CAUSE_BREAKPOINT : CAUSE_ECALL_M;
                            end else begin
                                causeNext = CAUSE_ILLEGAL;
                            end
                        end
                        default: begin
                            stateNext = ST_TRAP;
                            causeNext = CAUSE_ILLEGAL;
                        end
                    endcase
                end
                ST_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 1'b1;
                    stateNext = (opcode == OPC_STORE) ? ST_MEM_WR : ST_MEM_RD;
                end
                ST_MEM_RD: begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        stateNext = ST_MEM_WB;
                    end else if (waitTimeout) begin
                        stateNext = ST_TRAP;
                        causeNext = CAUSE_LOAD_FAULT;
                    end else begin
                        stateNext = ST_MEM_RD;
                    end
                end
                ST_MEM_WB: begin
                    reg_write     = 1'b1;
                    wb_sel        = WB_SEL_MEM;
                    pc_write      = 1'b1;
                    pc_sel        = PC_SEL_PC4;
                    instr_retired = 1'b1;
                end
                ST_MEM_WR: begin
                    dmem_req = 1'b1;
                    dmem_we  = 1'b1;
                    if (dmem_ready) begin
                        pc_write      = 1'b1;
                        pc_sel        = PC_SEL_PC4;
                        instr_retired = 1'b1;
                    end else if (waitTimeout) begin
                        stateNext = ST_TRAP;
                        causeNext = CAUSE_STORE_FAULT;
                    end else begin
                        stateNext = ST_MEM_WR;
                    end
                end
                ST_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = (opcode == OPC_OP_IMM);
                    alu_op    = ALU_OP_FUNCT;
                    stateNext = ST_ALU_WB;
                end
                ST_ALU_WB: begin
                    reg_write     = 1'b1;
                    wb_sel        = WB_SEL_ALU;
                    pc_write      = 1'b1;
                    pc_sel        = PC_SEL_PC4;
                    instr_retired = 1'b1;
                end
                ST_BR_CMP: begin
                    branch_op = funct3;
                    alu_src_b = 1'b1;
                    stateNext = ST_BR_RES;
                end
                ST_BR_RES: begin
                    branch_op     = funct3;
                    pc_write      = 1'b1;
                    pc_sel        = branch_taken ? PC_SEL_ALU : PC_SEL_PC4;
                    instr_retired = 1'b1;
                end
                ST_JUMP: begin
                    reg_write     = 1'b1;
                    wb_sel        = WB_SEL_PC4;
                    alu_src_a     = (opcode == OPC_JALR);
                    alu_src_b     = 1'b1;
                    pc_write      = 1'b1;
                    pc_sel        = PC_SEL_ALU;
                    instr_retired = 1'b1;
                end
                ST_UPPER: begin
                    alu_src_b = 1'b1;
                    alu_op    = (opcode == OPC_LUI) ? ALU_OP_PASSB : ALU_OP_ADD;
                    stateNext = ST_ALU_WB;
                end
                ST_FENCE: begin
                    pc_write      = 1'b1;
                    pc_sel        = PC_SEL_PC4;
                    instr_retired = 1'b1;
                end
                ST_TRAP: begin
                    trap     = 1'b1;
                    pc_write = 1'b1;
                    pc_sel   = PC_SEL_TRAP;
                end
                default: stateNext = ST_FETCH;
            endcase
        end
    end

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (instr_retired) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized scoreboard bench for mc_control_fsm: per-instruction expectations
// come from a latency/effect model; a monitor summarizes each instruction.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    localparam int TO = 16;
    localparam int C_OP = 0, C_OPIMM = 1, C_LUI = 2, C_AUIPC = 3, C_LOAD = 4,
                   C_STORE = 5, C_BRANCH = 6, C_JAL = 7, C_JALR = 8, C_FENCE = 9,
                   C_ECALL = 10, C_EBREAK = 11, C_SYSBAD = 12, C_ILLEGAL = 13, C_ILL7F = 14;

    logic clk = 1'b0, rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic sys_imm0 = 1'b0, branch_taken = 1'b0;
    logic imem_ready = 1'b0, dmem_ready = 1'b0;
    logic imem_req, ir_write, dmem_req, dmem_we, pc_write, reg_write;
    logic alu_src_a, alu_src_b, trap, instr_retired;
    logic [1:0] pc_sel, wb_sel, alu_op;
    logic [2:0] branch_op;
    logic [3:0] trap_cause, state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    mc_control_fsm #(.TIMEOUT_CYC(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .sys_imm0(sys_imm0),
        .branch_taken(branch_taken), .imem_req(imem_req), .imem_ready(imem_ready),
        .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .pc_sel(pc_sel), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .branch_op(branch_op),
        .trap(trap), .trap_cause(trap_cause), .state(state), .instr_retired(instr_retired)
`ifdef MC_CTRL_PERF_EN
       ,.cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    wire [22:0] allOut = {imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_sel, reg_write,
                          wb_sel, alu_src_a, alu_src_b, alu_op, branch_op, trap, trap_cause,
                          instr_retired};

    typedef struct {
        int cycles; int retired; int traps; int cause; int regWrites; int rwCycle;
        int wbSel; int pcSel; int irWrites; int imemCyc; int dmemCyc; int weCyc;
        int srcACyc; int srcBCyc; int opFunctCyc; int opPassCyc; int brOpOr;
    } rec_t;

    rec_t expQ[$];
    rec_t acc;
    int vectors = 0, miscompares = 0;
    int doneCount = 0, nonRst = 0, retiredTally = 0, lastCause = 0;
    int fetchWait = 0, dataWait = 0, iCnt = 0, dCnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finishBench();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // Memory models: ready after the planned number of wait cycles.
    always @(negedge clk) begin
        if (imem_req) begin imem_ready = (iCnt == fetchWait); iCnt++; end
        else begin imem_ready = 1'b0; iCnt = 0; end
        if (dmem_req) begin dmem_ready = (dCnt == dataWait); dCnt++; end
        else begin dmem_ready = 1'b0; dCnt = 0; end
    end

    function automatic rec_t model(input int cls, input int fw, input int dw, input bit tk,
                                   input logic [2:0] f3, input int prevCause);
        rec_t e;
        int f;
        bit dFault;
        e = '{default: 0};
        e.cause = prevCause;
        if (fw >= TO) begin
            e.cycles = TO + 1; e.imemCyc = TO; e.traps = 1; e.cause = 1; e.pcSel = 2;
            return e;
        end
        f = fw + 1; e.imemCyc = f; e.irWrites = 1;
        dFault = (dw >= TO);
        case (cls)
            C_OP, C_OPIMM, C_LUI, C_AUIPC: begin
                e.cycles = f + 3; e.retired = 1; e.regWrites = 1; e.rwCycle = e.cycles; e.pcSel = 1;
                e.srcACyc = int'(cls == C_OP || cls == C_OPIMM);
                e.srcBCyc = int'(cls != C_OP);
                e.opFunctCyc = int'(cls == C_OP || cls == C_OPIMM);
                e.opPassCyc = int'(cls == C_LUI);
            end
            C_LOAD, C_STORE: begin
                e.srcACyc = 1; e.srcBCyc = 1;
                e.dmemCyc = dFault ? TO : dw + 1;
                if (cls == C_STORE) e.weCyc = e.dmemCyc;
                if (dFault) begin
                    e.cycles = f + TO + 3; e.traps = 1; e.pcSel = 2;
                    e.cause = (cls == C_LOAD) ? 5 : 7;
                end else if (cls == C_LOAD) begin
                    e.cycles = f + dw + 4; e.retired = 1; e.regWrites = 1; e.rwCycle = e.cycles;
                    e.wbSel = 1; e.pcSel = 1;
                end else begin
                    e.cycles = f + dw + 3; e.retired = 1; e.pcSel = 1;
                end
            end
            C_BRANCH: begin
                e.cycles = f + 3; e.retired = 1; e.pcSel = tk ? 0 : 1; e.srcBCyc = 1; e.brOpOr = int'(f3);
            end
            C_JAL, C_JALR: begin
                e.cycles = f + 2; e.retired = 1; e.regWrites = 1; e.rwCycle = e.cycles;
                e.wbSel = 2; e.pcSel = 0; e.srcBCyc = 1; e.srcACyc = int'(cls == C_JALR);
            end
            C_FENCE: begin
                e.cycles = f + 2; e.retired = 1; e.pcSel = 1;
            end
            default: begin
                e.cycles = f + 2; e.traps = 1; e.pcSel = 2;
                e.cause = (cls == C_ECALL) ? 11 : (cls == C_EBREAK) ? 3 : 2;
            end
        endcase
        return e;
    endfunction

    task automatic compareRec(input rec_t a, input rec_t e);
        chk("cycles", a.cycles, e.cycles);           chk("retired", a.retired, e.retired);
        chk("trap_pulses", a.traps, e.traps);        chk("trap_cause", a.cause, e.cause);
        chk("reg_writes", a.regWrites, e.regWrites); chk("reg_write_cycle", a.rwCycle, e.rwCycle);
        chk("wb_sel", a.wbSel, e.wbSel);             chk("pc_sel", a.pcSel, e.pcSel);
        chk("ir_writes", a.irWrites, e.irWrites);    chk("imem_req_cycles", a.imemCyc, e.imemCyc);
        chk("dmem_req_cycles", a.dmemCyc, e.dmemCyc); chk("dmem_we_cycles", a.weCyc, e.weCyc);
        chk("alu_src_a_cycles", a.srcACyc, e.srcACyc); chk("alu_src_b_cycles", a.srcBCyc, e.srcBCyc);
        chk("alu_op_funct_cycles", a.opFunctCyc, e.opFunctCyc);
        chk("alu_op_passb_cycles", a.opPassCyc, e.opPassCyc);
        chk("branch_op", a.brOpOr, e.brOpOr);
    endtask

    // Monitor: summarize each instruction up to its pc_write cycle, then score it.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            acc = '{default: 0};
            nonRst = 0;
        end else begin
            nonRst++;
            acc.cycles++;
            if (reg_write) begin acc.regWrites++; acc.rwCycle = acc.cycles; acc.wbSel = int'(wb_sel); end
            acc.retired += int'(instr_retired);
            acc.traps += int'(trap);
            acc.irWrites += int'(ir_write);
            acc.imemCyc += int'(imem_req);
            acc.dmemCyc += int'(dmem_req);
            acc.weCyc += int'(dmem_we);
            acc.srcACyc += int'(alu_src_a);
            acc.srcBCyc += int'(alu_src_b);
            if (alu_op == 2'b10) acc.opFunctCyc++;
            if (alu_op == 2'b11) acc.opPassCyc++;
            acc.brOpOr |= int'(branch_op);
            if (pc_write) begin
                acc.pcSel = int'(pc_sel);
                acc.cause = int'(trap_cause);
                if (expQ.size() == 0) chk("unexpected_completion", 1, 0);
                else compareRec(acc, expQ.pop_front());
                acc = '{default: 0};
                doneCount++;
            end
        end
    end

    task automatic issue(input int cls, input int fw, input int dw, input bit tk);
        logic [6:0] opc;
        logic [2:0] f3;
        logic imm;
        logic [6:0] ill [6];
        rec_t e;
        int start;
        ill = '{7'h7F, 7'h00, 7'h0B, 7'h2B, 7'h5B, 7'h77};
        f3 = 3'($urandom_range(0, 7));
        imm = 1'($urandom_range(0, 1));
        case (cls)
            C_OP:     opc = 7'b0110011;
            C_OPIMM:  opc = 7'b0010011;
            C_LUI:    opc = 7'b0110111;
            C_AUIPC:  opc = 7'b0010111;
            C_LOAD:   opc = 7'b0000011;
            C_STORE:  opc = 7'b0100011;
            C_BRANCH: opc = 7'b1100011;
            C_JAL:    opc = 7'b1101111;
            C_JALR:   opc = 7'b1100111;
            C_FENCE:  opc = 7'b0001111;
            C_ECALL:  begin opc = 7'b1110011; f3 = 3'd0; imm = 1'b0; end
            C_EBREAK: begin opc = 7'b1110011; f3 = 3'd0; imm = 1'b1; end
            C_SYSBAD: begin opc = 7'b1110011; f3 = 3'($urandom_range(1, 7)); end
            C_ILL7F:  opc = 7'h7F;
            default:  opc = ill[$urandom_range(0, 5)];
        endcase
        opcode = opc; funct3 = f3; sys_imm0 = imm; branch_taken = tk;
        fetchWait = fw; dataWait = dw;
        e = model(cls, fw, dw, tk, f3, lastCause);
        lastCause = e.cause;
        retiredTally += e.retired;
        expQ.push_back(e);
        start = doneCount;
        for (int i = 0; i < 400 && doneCount == start; i++) @(posedge clk);
        if (doneCount == start) begin
            chk("instruction_completion_timeout", 0, 1);
            finishBench();
        end
        #1;
    endtask

    function automatic int pickWait();
        int r;
        r = $urandom_range(0, 11);
        if (r < 8) return $urandom_range(0, 3);
        if (r == 8) return TO - 1;
        if (r == 9) return TO;
        if (r == 10) return 0;
        return $urandom_range(TO + 1, TO + 10);
    endfunction

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_outputs_zero", int'(allOut), 0);
        chk("reset_state", int'(state), int'(ST_FETCH));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_reset_state", int'(state), int'(ST_FETCH));
        chk("post_reset_cause", int'(trap_cause), 0);
`ifdef MC_CTRL_PERF_EN
        chk("post_reset_cycle_cnt", int'(cycle_cnt), 0);
        chk("post_reset_instret_cnt", int'(instret_cnt), 0);
`endif
        issue(C_OP, 0, 0, 1'b0);
        issue(C_LOAD, 0, 3, 1'b0);
        issue(C_BRANCH, 0, 0, 1'b1);
        issue(C_BRANCH, 0, 0, 1'b0);
        issue(C_ILL7F, 0, 0, 1'b0);
        issue(C_ECALL, 0, 0, 1'b0);
        issue(C_EBREAK, 0, 0, 1'b0);
        issue(C_OP, TO + 4, 0, 1'b0);
        issue(C_OP, TO - 1, 0, 1'b0);
        issue(C_STORE, 0, 0, 1'b0);
        issue(C_JAL, 0, 0, 1'b0);
        issue(C_LOAD, 0, TO + 4, 1'b0);
        issue(C_STORE, 1, TO - 1, 1'b0);
        issue(C_STORE, 0, TO, 1'b0);
        issue(C_LUI, 0, 0, 1'b0);

        // Reset while a store waits for dmem_ready.
        opcode = 7'b0100011; funct3 = 3'd2; fetchWait = 0; dataWait = 200;
        n = 0;
        while (!dmem_req && n < 50) begin @(negedge clk); #1; n++; end
        chk("midop_store_reached", int'(dmem_req), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk); #1;
        chk("midop_rst_dmem_req", int'(dmem_req), 0);
        chk("midop_rst_outputs_zero", int'(allOut), 0);
        @(posedge clk); #1;
        chk("midop_rst_state", int'(state), int'(ST_FETCH));
        rst = 1'b0;
        lastCause = 0;
        retiredTally = 0;
        #1;
        chk("midop_rst_cause_cleared", int'(trap_cause), 0);
`ifdef MC_CTRL_PERF_EN
        chk("midop_rst_cycle_cnt", int'(cycle_cnt), 0);
        chk("midop_rst_instret_cnt", int'(instret_cnt), 0);
`endif

        for (int k = 0; k < 80; k++) begin
            issue($urandom_range(0, 14), pickWait(), pickWait(), 1'($urandom_range(0, 1)));
        end

`ifdef MC_CTRL_PERF_EN
        chk("cycle_cnt_total", int'(cycle_cnt), nonRst);
        chk("instret_cnt_total", int'(instret_cnt), retiredTally);
`endif
        chk("scoreboard_drained", expQ.size(), 0);
        finishBench();
    end

    initial begin
        #400000;
        chk("global_watchdog", 0, 1);
        finishBench();
    end

endmodule
